// File: rtl/ibex_pkg.sv
// Shared types and legal parameter ranges for the CHERI memory responder.
package ibex_pkg;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_HI   = 1'b1
  } cap_state_e;

  localparam int unsigned RespLatencyMin    = 1;
  localparam int unsigned RespLatencyMax    = 4;
  localparam int unsigned MaxOutstandingMin = 1;
  localparam int unsigned MaxOutstandingMax = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        tag;
    logic        err;
  } resp_t;

endpackage

// File: rtl/ibex_cheri_tag_store.sv
// One tag bit per 8-byte granule: single write port, combinational read port,
// and every bit cleared asynchronously by reset.
module ibex_cheri_tag_store #(
  parameter int unsigned GranAw = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [GranAw-1:0] waddr_i,
  input  logic              wdata_i,
  input  logic [GranAw-1:0] raddr_i,
  output logic              rdata_o
);

  logic [(2**GranAw)-1:0] tags_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tags_q <= '0;
    end else if (we_i) begin
      tags_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = tags_q[raddr_i];

endmodule

// File: rtl/ibex_cheri_mem_responder.sv
// Ibex data-port memory model with CHERI tags and a fixed-latency response pipe.
// CAP_IDLE | no capability beat pending ; CAP_HI | low beat granted, high beat expected
module ibex_cheri_mem_responder
  import ibex_pkg::*;
#(
  parameter int unsigned MemSizeBytes   = 16384,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_cap_i,
  input  logic        data_wdata_tag_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rdata_tag_o,
  output logic        data_err_o
);

  localparam int unsigned Aw     = $clog2(MemSizeBytes);
  localparam int unsigned Words  = MemSizeBytes / 4;
  localparam int unsigned Lat    = (RespLatency < RespLatencyMin) ? RespLatencyMin :
                                   (RespLatency > RespLatencyMax) ? RespLatencyMax : RespLatency;
  localparam int unsigned MaxOut = (MaxOutstanding < MaxOutstandingMin) ? MaxOutstandingMin :
                                   (MaxOutstanding > MaxOutstandingMax) ? MaxOutstandingMax :
                                   MaxOutstanding;

  logic [31:0]    mem_q [Words];
  cap_state_e     state_q, state_d;
  logic [31:0]    lat_addr_q;
  logic           lat_we_q, lat_tag_q;
  logic [2:0]     out_q;
  resp_t          pipe_q [Lat];
  resp_t          resp_d;

  logic           gnt, rvalid, in_range, hi_match, latch, mem_we;
  logic           tag_we, tag_wdata, tag_rd;
  logic [Aw-4:0]  tag_waddr;
  logic [31:0]    mem_rd;

  assign gnt      = ~rst_i & data_req_i & (out_q < 3'(MaxOut));
  assign rvalid   = pipe_q[Lat-1].valid;
  assign in_range = data_addr_i < 32'(MemSizeBytes);
  assign hi_match = data_cap_i && (data_addr_i == lat_addr_q + 32'd4) && (data_we_i == lat_we_q);
  assign mem_rd   = mem_q[data_addr_i[Aw-1:2]];

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    mem_we    = 1'b0;
    tag_we    = 1'b0;
    tag_waddr = data_addr_i[Aw-1:3];
    tag_wdata = 1'b0;
    resp_d    = '0;
    if (gnt) begin
      resp_d.valid = 1'b1;
      if (state_q == CAP_HI) begin
        state_d = CAP_IDLE;
        if (hi_match) begin
          if (data_we_i) begin
            mem_we    = 1'b1;
            tag_we    = 1'b1;
            tag_wdata = lat_tag_q & data_wdata_tag_i;
          end else begin
            resp_d.rdata = mem_rd;
            resp_d.tag   = tag_rd;
          end
        end else begin
          // A broken pair invalidates the capability the low beat belonged to.
          resp_d.err = 1'b1;
          tag_we     = 1'b1;
          tag_waddr  = lat_addr_q[Aw-1:3];
        end
      end else if (!in_range || (data_cap_i && (data_addr_i[2:0] != 3'b000))) begin
        resp_d.err = 1'b1;
      end else begin
        if (data_cap_i) begin
          state_d = CAP_HI;
          latch   = 1'b1;
        end
        if (data_we_i) begin
          mem_we = 1'b1;
          tag_we = ~data_cap_i & (|data_be_i);
        end else begin
          resp_d.rdata = mem_rd;
          resp_d.tag   = data_cap_i & tag_rd;
        end
      end
    end
  end

  ibex_cheri_tag_store #(
    .GranAw (Aw - 3)
  ) u_tag_store (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (tag_we),
    .waddr_i (tag_waddr),
    .wdata_i (tag_wdata),
    .raddr_i (data_addr_i[Aw-1:3]),
    .rdata_o (tag_rd)
  );

  // Data array deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[data_addr_i[Aw-1:2]][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CAP_IDLE;
      lat_addr_q <= '0;
      lat_we_q   <= 1'b0;
      lat_tag_q  <= 1'b0;
      out_q      <= '0;
      for (int i = 0; i < Lat; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_q + 3'(gnt) - 3'(rvalid);
      if (latch) begin
        lat_addr_q <= data_addr_i;
        lat_we_q   <= data_we_i;
        lat_tag_q  <= data_wdata_tag_i;
      end
      pipe_q[0] <= resp_d;
      for (int i = 1; i < Lat; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign data_gnt_o       = gnt;
  assign data_rvalid_o    = rvalid;
  assign data_rdata_o     = pipe_q[Lat-1].rdata;
  assign data_rdata_tag_o = pipe_q[Lat-1].tag;
  assign data_err_o       = pipe_q[Lat-1].err;

endmodule

// File: tb/tb_ibex_cheri_mem_responder.sv
// Scoreboard bench: the driver queues the expected response at each grant and
// a negedge monitor pops and compares whenever rvalid is high.
module tb_ibex_cheri_mem_responder;

  localparam int unsigned MEM  = 16384;
  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, cap = 1'b0, wtag = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rvalid, rtag, err;
  logic [31:0] rdata;

  ibex_cheri_mem_responder #(
    .MemSizeBytes   (MEM),
    .RespLatency    (LAT),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .data_req_i       (req),
    .data_gnt_o       (gnt),
    .data_rvalid_o    (rvalid),
    .data_addr_i      (addr),
    .data_we_i        (we),
    .data_be_i        (be),
    .data_wdata_i     (wdata),
    .data_cap_i       (cap),
    .data_wdata_tag_i (wtag),
    .data_rdata_o     (rdata),
    .data_rdata_tag_o (rtag),
    .data_err_o       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic        tag;
    logic        err;
    int          gcyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   next_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_gnt", 32'(gnt), 0);
      chk("reset_rvalid", 32'(rvalid), 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_tag", 32'(rtag), 0);
      chk("reset_err", 32'(err), 0);
    end else if (rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid with empty scoreboard at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("resp%0d_rdata", mon_e.id), rdata, mon_e.rdata);
        chk($sformatf("resp%0d_tag", mon_e.id), 32'(rtag), 32'(mon_e.tag));
        chk($sformatf("resp%0d_err", mon_e.id), 32'(err), 32'(mon_e.err));
        chk($sformatf("resp%0d_latency", mon_e.id), 32'(cyc - mon_e.gcyc), LAT);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input logic c, input logic t,
                       input logic [31:0] er, input logic et, input logic ee,
                       output int waits);
    req = 1'b1; addr = a; we = w; be = b; wdata = d; cap = c; wtag = t;
    waits = 0;
    forever begin
      @(negedge clk);
      if (gnt) begin
        sb.push_back('{er, et, ee, cyc, next_id});
        next_id++;
        @(posedge clk); #1;
        return;
      end
      waits++;
      if (waits > 50) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout: got no gnt for addr %h expected gnt within 50 cycles", a);
        req = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic ld(input logic [31:0] a, input logic c, input logic [31:0] er,
                    input logic et, input logic ee);
    int w;
    issue(a, 1'b0, 4'hF, 32'h0, c, 1'b0, er, et, ee, w);
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                    input logic c, input logic t, input logic ee);
    int w;
    issue(a, 1'b1, b, d, c, t, 32'h0, 1'b0, ee, w);
  endtask

  task automatic drain();
    int n;
    req = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  int w0, w1, w2;

  initial begin
    req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Legal cap store then cap load of the pair at 0x100
    st(32'h100, 4'hF, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b0);
    st(32'h104, 4'hF, 32'h11223344, 1'b1, 1'b1, 1'b0);
    ld(32'h100, 1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
    ld(32'h104, 1'b1, 32'h11223344, 1'b1, 1'b0);
    ld(32'h100, 1'b0, 32'hA1B2C3D4, 1'b0, 1'b0);

    // Byte store into the granule clears its tag
    st(32'h103, 4'b1000, 32'hEE000000, 1'b0, 1'b0, 1'b0);
    ld(32'h100, 1'b1, 32'hEEB2C3D4, 1'b0, 1'b0);
    ld(32'h104, 1'b1, 32'h11223344, 1'b0, 1'b0);

    // Broken cap load pair: second beat at 0x10C
    st(32'h100, 4'hF, 32'h0BADF00D, 1'b1, 1'b1, 1'b0);
    st(32'h104, 4'hF, 32'hCAFEBABE, 1'b1, 1'b1, 1'b0);
    ld(32'h100, 1'b1, 32'h0BADF00D, 1'b1, 1'b0);
    ld(32'h10C, 1'b1, 32'h0, 1'b0, 1'b1);
    ld(32'h100, 1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    ld(32'h104, 1'b1, 32'hCAFEBABE, 1'b0, 1'b0);

    // Cap access starting at a high word errors and writes nothing
    st(32'h108, 4'hF, 32'h55667788, 1'b0, 1'b0, 1'b0);
    st(32'h10C, 4'hF, 32'h99AABBCC, 1'b0, 1'b0, 1'b0);
    st(32'h10C, 4'hF, 32'hDEADDEAD, 1'b1, 1'b1, 1'b1);
    ld(32'h10C, 1'b0, 32'h99AABBCC, 1'b0, 1'b0);

    // Out-of-range accesses; 0x4000 would alias word 0 if it wrote
    st(32'h0, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b0);
    st(MEM, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    ld(MEM, 1'b0, 32'h0, 1'b0, 1'b1);
    ld(32'h0, 1'b0, 32'h12345678, 1'b0, 1'b0);

    // Back-to-back loads throttled by the outstanding limit
    drain();
    issue(32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, w0);
    issue(32'h104, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'hCAFEBABE, 1'b0, 1'b0, w1);
    issue(32'h108, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h55667788, 1'b0, 1'b0, w2);
    chk("throttle_wait0", 32'(w0), 0);
    chk("throttle_wait1", 32'(w1), 0);
    chk("throttle_wait2", 32'(w2), 2);
    drain();

    // Reset between the two beats of a cap store
    st(32'h100, 4'hF, 32'h0BADF00D, 1'b1, 1'b1, 1'b0);
    st(32'h104, 4'hF, 32'hCAFEBABE, 1'b1, 1'b1, 1'b0);
    ld(32'h100, 1'b1, 32'h0BADF00D, 1'b1, 1'b0);
    ld(32'h104, 1'b1, 32'hCAFEBABE, 1'b1, 1'b0);
    drain();
    st(32'h200, 4'hF, 32'h77777777, 1'b1, 1'b1, 1'b0);
    req = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    ld(32'h100, 1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    ld(32'h104, 1'b1, 32'hCAFEBABE, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ibex_cheri_mem_responder.md
IBEX_CHERI_MEM_RESPONDER -- requirements
Module: ibex_cheri_mem_responder

Interface
REQ-001 SHALL have parameter MemSizeBytes, default 16384, meaning backing store size in bytes (power of two, multiple of 8).
REQ-002 SHALL have parameter RespLatency, default 1, meaning cycles from grant to rvalid (legal 1..4).
REQ-003 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted-but-unanswered requests (legal 1..4).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all flops on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, the reset, asynchronous and active-high.
REQ-006 SHALL have ports data_req_i in 1, data_gnt_o out 1, data_rvalid_o out 1, giving the Ibex-style request/grant/response handshake.
REQ-007 SHALL have ports data_addr_i in 32, data_we_i in 1, data_be_i in 4, data_wdata_i in 32, carrying the word-aligned request fields.
REQ-008 SHALL have port data_cap_i, input, 1, set when the access is one beat of a capability access.
REQ-009 SHALL have port data_wdata_tag_i, input, 1, carrying the tag of the capability being stored, valid on both beats.
REQ-010 SHALL have ports data_rdata_o out 32, data_rdata_tag_o out 1 and data_err_o out 1, all valid only while data_rvalid_o is high.

Function
REQ-011 SHALL drive data_gnt_o = data_req_i & (outstanding < MaxOutstanding); the outstanding count increments on grant and decrements on rvalid, and a grant and rvalid in the same cycle leave it unchanged.
REQ-012 SHALL assert data_rvalid_o exactly RespLatency cycles after each grant cycle, with responses in grant order and one rvalid per grant.
REQ-013 SHALL index memory with addr[log2(MemSizeBytes)-1:2]; any addr >= MemSizeBytes SHALL produce err=1 with rdata 0 and tag 0, and a store to such an address SHALL write nothing.
REQ-014 SHALL, on a store, write only the bytes whose data_be_i bits are set; on a load, it SHALL return the full word regardless of data_be_i.
REQ-015 SHALL keep one tag bit per 8-byte granule, indexed by addr[log2(MemSizeBytes)-1:3].
REQ-016 SHALL run a beat FSM with states CAP_IDLE and CAP_HI. From CAP_IDLE, a granted cap access with addr[2:0]==0 moves the FSM to CAP_HI and latches the address, we and tag. From CAP_HI, the next grant returns the FSM to CAP_IDLE.
REQ-017 SHALL, in CAP_IDLE, answer a granted cap access with addr[2]==1 with err=1 and no write; the FSM stays in CAP_IDLE.
REQ-018 SHALL, in CAP_HI, require the next granted access to have cap=1, addr equal to the latched address+4, and matching we; on a mismatch, that access SHALL get err=1 and no write, the granule tag SHALL be cleared, and the FSM returns to CAP_IDLE.
REQ-019 SHALL, on a legal cap store, write both words and set the granule tag to (low-beat tag AND high-beat tag), updating the tag on the high-beat grant.
REQ-020 SHALL, on a non-cap store with any data_be_i bit set, clear the granule tag in the grant cycle.
REQ-021 SHALL return the granule tag on both beats of a legal cap load, and tag 0 for non-cap loads.
REQ-022 SHALL make a load that is granted after a store to the same word (or granule) observe the store's data and tag, given in-order, single-port semantics.

Reset
REQ-023 SHALL, while rst_i is high, drive data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_rdata_tag_o=0 and data_err_o=0.
REQ-024 SHALL, while rst_i is high, set outstanding=0, the FSM to CAP_IDLE and every tag bit to 0, and discard all in-flight responses.
REQ-025 SHALL NOT initialise the data array on reset.
REQ-026 SHALL drop any half-completed cap store on reset without writing a tag.

Structure
REQ-027 SHALL place the cap beat FSM state enum and the legal range limits for RespLatency and MaxOutstanding in ibex_pkg.
REQ-028 SHALL implement the tag array as a sub-module, ibex_cheri_tag_store, with one write port, one read port and an asynchronous clear; data storage and the response pipeline SHALL stay in the top-level module.

Verification
REQ-029 SHALL cover: cap store to 0x100 with both tags 1 -> cap load of 0x100 and 0x104 returns both words with tag=1 on each beat and err=0.
REQ-030 SHALL cover: after REQ-029, a byte store to 0x103 with be=4'b1000 -> a later cap load of 0x100 returns tag=0.
REQ-031 SHALL cover: cap load whose low beat is at 0x100 and whose next beat is at 0x10C -> the second beat gets err=1, the tag is cleared, and the FSM returns to CAP_IDLE.
REQ-032 SHALL cover: RespLatency=3 with MaxOutstanding=2 and req held high -> gnt is deasserted on the third request until the first rvalid, with rvalid exactly 3 cycles after each grant.
REQ-033 SHALL cover: a store to address MemSizeBytes -> err=1 with no memory change.
REQ-034 SHALL cover: rst_i asserted between the two beats of a cap store -> no rvalid while in reset, all tags read 0 afterwards, and the FSM is in CAP_IDLE.
